aud_i2s_tx_fifo: RTL

//  Parametrised I2S DAC transmitter with an input sample FIFO, for the audio playback path.

---
 rtl/aud_pkg.sv | 17 +
 rtl/aud_sync_fifo.sv | 47 ++++
 rtl/aud_i2s_tx_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared types and defaults for the I2S DAC transmit path.
package aud_pkg;

    localparam int AUD_DATA_W = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LEFT  = 2'd1,
        TX_RIGHT = 2'd2
    } aud_tx_state_e;

    typedef struct packed {
        logic signed [AUD_DATA_W-1:0] left;
        logic signed [AUD_DATA_W-1:0] right;
    } aud_frame_t;

endpackage

// File: rtl/aud_sync_fifo.sv
// Single-clock FIFO with occupancy output; full/empty derived from the pointer difference.
module aud_sync_fifo
    import aud_pkg::*;
#(
    parameter int WIDTH = 2 * AUD_DATA_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/aud_i2s_tx_fifo.sv
// I2S DAC transmitter fed by a frame FIFO; one frame is popped at each left-slot start.
// Build option AUD_TX_HOLD_LAST_EN: on underrun repeat the last frame instead of sending silence.
module aud_i2s_tx_fifo
    import aud_pkg::*;
#(
    parameter int DATA_W  = AUD_DATA_W,
    parameter int DEPTH   = 4,
    parameter int MONO    = 0,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                     i_bclk,
    input  logic                     i_rst_n,
    input  logic                     i_daclrck,
    input  logic                     i_en,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [DATA_W-1:0] i_left,
    input  logic signed [DATA_W-1:0] i_right,
    output logic                     o_aud_dacdat,
    output logic [LVL_W-1:0]         o_level,
    output logic                     o_underrun
);

    localparam int FIFO_W = DATA_W * (2 - MONO);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    aud_tx_state_e state;
    aud_tx_state_e state_next;

    logic               lrck_q;
    logic               fall;
    logic               rise;
    logic               pop_req;
    logic               load;
    logic               full;
    logic               empty;
    logic [FIFO_W-1:0]  wr_data;
    logic [FIFO_W-1:0]  rd_data;
    logic signed [DATA_W-1:0] fifo_l, fifo_r;
    logic signed [DATA_W-1:0] frame_l, frame_r;
    logic signed [DATA_W-1:0] next_l, next_r;
    logic signed [DATA_W-1:0] slot_word;
    logic [DATA_W-1:0]  shift;
    logic [CNT_W-1:0]   cnt;

    generate
        if (MONO != 0) begin : g_mono
            assign wr_data = i_left;
            assign fifo_l  = rd_data;
            assign fifo_r  = rd_data;
        end else begin : g_stereo
            assign wr_data = {i_left, i_right};
            assign fifo_l  = rd_data[FIFO_W-1 -: DATA_W];
            assign fifo_r  = rd_data[DATA_W-1:0];
        end
    endgenerate

    aud_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_bclk),
        .rst_n   (i_rst_n),
        .push    (i_valid),
        .wr_data (wr_data),
        .pop     (pop_req),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (o_level)
    );

    assign fall       = lrck_q & ~i_daclrck;
    assign rise       = ~lrck_q & i_daclrck;
    // Enable is only looked at on the left-slot boundary, so a frame always completes.
    assign pop_req    = fall & i_en & (state != TX_LEFT);
    assign load       = pop_req | (rise & (state == TX_LEFT));
    assign o_underrun = pop_req & empty;
    assign o_ready    = ~full;

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (fall && i_en) state_next = TX_LEFT;
            TX_LEFT:  if (rise) state_next = TX_RIGHT;
            TX_RIGHT: if (fall) state_next = i_en ? TX_LEFT : TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        next_l = frame_l;
        next_r = frame_r;
        if (pop_req) begin
            if (!empty) begin
                next_l = fifo_l;
                next_r = fifo_r;
            end
`ifdef AUD_TX_HOLD_LAST_EN
            else begin
                next_l = frame_l;
                next_r = frame_r;
            end
`else
            else begin
                next_l = '0;
                next_r = '0;
            end
`endif
        end
    end

    // The popped word must go out on the same edge it is read, so bypass the frame register.
    always_comb begin
        slot_word = (MONO != 0) ? frame_l : frame_r;
        if (pop_req) slot_word = next_l;
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q  <= 1'b0;
            state   <= TX_IDLE;
            frame_l <= '0;
            frame_r <= '0;
        end else begin
            lrck_q  <= i_daclrck;
            state   <= state_next;
            frame_l <= next_l;
            frame_r <= next_r;
        end
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_aud_dacdat <= 1'b0;
            cnt          <= '0;
        end else if (state_next == TX_IDLE) begin
            o_aud_dacdat <= 1'b0;
            cnt          <= '0;
        end else if (load) begin
            o_aud_dacdat <= slot_word[DATA_W-1];
            cnt          <= CNT_W'(1);
        end else if (cnt < CNT_W'(DATA_W)) begin
            o_aud_dacdat <= shift[DATA_W-1];
            cnt          <= cnt + 1'b1;
        end else begin
            o_aud_dacdat <= 1'b0;
        end
    end

    always_ff @(posedge i_bclk) begin
        if (load) shift <= {slot_word[DATA_W-2:0], 1'b0};
        else      shift <= {shift[DATA_W-2:0], 1'b0};
    end

endmodule
